int_seq: RTL and testbench

INT_SEQ -- requirements
Module: int_seq

---
 rtl/int_seq_pkg.sv | 43 ++++
 rtl/int_arb.sv | 23 ++
 rtl/int_seq.sv | 146 ++++++++++++++
 tb/tb_int_seq.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/int_seq_pkg.sv
// Shared control encodings for the interrupt sequencer: FSM states, cause
// codes, SPR write-target codes, IVOR numbers and the MSR[EE] position.
package int_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SAVE0 = 3'd1,
    S_SAVE1 = 3'd2,
    S_MSRW  = 3'd3,
    S_JUMP  = 3'd4,
    S_RFI_M = 3'd5,
    S_RFI_J = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    C_TRAP = 2'd0,
    C_SC   = 2'd1,
    C_RFI  = 2'd2,
    C_EXT  = 2'd3
  } cause_t;

  localparam logic [1:0] SEL_SRR0 = 2'd0;
  localparam logic [1:0] SEL_SRR1 = 2'd1;
  localparam logic [1:0] SEL_MSR  = 2'd2;

  localparam logic [3:0] IVOR_TRAP = 4'd6;
  localparam logic [3:0] IVOR_SC   = 4'd8;
  localparam logic [3:0] IVOR_EXT  = 4'd4;

  // EE position in MSB-0 numbering; convert with (SPR_W-1-EE_BIT).
  localparam int EE_BIT = 16;

  // rfi has no vector; it reports IVOR 0.
  function automatic logic [3:0] cause_ivor(cause_t c);
    case (c)
      C_TRAP:  return IVOR_TRAP;
      C_SC:    return IVOR_SC;
      C_EXT:   return IVOR_EXT;
      default: return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/int_arb.sv
// Fixed-priority cause encoder: trap > sc > rfi > ext.
module int_arb
  import int_seq_pkg::*;
(
  input  logic       i_trap,
  input  logic       i_sc,
  input  logic       i_rfi,
  input  logic       i_ext,
  output logic       o_vld,
  output logic [1:0] o_cause
);

  // Highest-priority active request wins.
  always_comb begin
    o_vld   = i_trap | i_sc | i_rfi | i_ext;
    o_cause = C_TRAP;
    if (i_trap)     o_cause = C_TRAP;
    else if (i_sc)  o_cause = C_SC;
    else if (i_rfi) o_cause = C_RFI;
    else if (i_ext) o_cause = C_EXT;
  end

endmodule

// File: rtl/int_seq.sv
// Interrupt/return sequencer: on trap, sc or external interrupt, saves PC and
// MSR to SRR0/SRR1, clears EE and jumps to the IVOR vector; on rfi, restores
// MSR from SRR1 and returns to SRR0.
module int_seq
  import int_seq_pkg::*;
#(
  parameter int SPR_W = 32,
  parameter int PC_W  = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_trap_req,
  input  logic             i_sc_req,
  input  logic             i_rfi_req,
  input  logic             i_hw_int,
  input  logic [PC_W-1:0]  i_pc_ex,
  input  logic [SPR_W-1:0] i_msr,
  input  logic [SPR_W-1:0] i_srr0,
  input  logic [SPR_W-1:0] i_srr1,
  input  logic [SPR_W-1:0] i_ivpr,
  input  logic [SPR_W-1:0] i_ivor,
  output logic [3:0]       o_ivor_idx,
  output logic             o_stall,
  output logic             o_flush,
  output logic             o_spr_we,
  output logic [1:0]       o_spr_sel,
  output logic [SPR_W-1:0] o_spr_wdata,
  output logic             o_npc_we,
  output logic [PC_W-1:0]  o_npc,
  output logic             o_busy
);

  localparam int EE_IDX = SPR_W - 1 - EE_BIT;

  state_t          r_state, w_state_nxt;
  cause_t          r_cause;
  logic [PC_W-1:0] r_pc;
  logic            r_pend;

  logic             w_ee, w_ext, w_arb_vld, w_take;
  logic [1:0]       w_arb_cause;
  logic [PC_W-1:0]  w_save_pc;
  logic [SPR_W-1:0] w_vec, w_ret, w_ee_mask;
  logic             w_unused;

  assign w_ee      = i_msr[EE_IDX];
  // Pending ext is only offered while EE is set, so it is not retaken after MSRW.
  assign w_ext     = r_pend & w_ee;
  assign w_take    = (r_state == S_IDLE) & w_arb_vld;
  assign w_save_pc = (r_cause == C_SC) ? r_pc + PC_W'(4) : r_pc;
  assign w_ee_mask = SPR_W'(1) << EE_IDX;
  // Vector = ivpr[0:15] | ivor[16:27] | 4'h0 (MSB-0 numbering).
  assign w_vec     = SPR_W'({i_ivpr[SPR_W-1 -: 16], i_ivor[SPR_W-17 -: 12], 4'h0});
  assign w_ret     = i_srr0 & ~SPR_W'(3);
  assign w_unused  = ^{i_ivor[SPR_W-1 -: 16], i_ivor[3:0], i_ivpr[SPR_W-17:0]};

  int_arb u_arb (
    .i_trap  (i_trap_req),
    .i_sc    (i_sc_req),
    .i_rfi   (i_rfi_req),
    .i_ext   (w_ext),
    .o_vld   (w_arb_vld),
    .o_cause (w_arb_cause)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Cause/pc capture on the taking edge; pend set by EE-qualified hw_int.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cause <= C_TRAP;
      r_pc    <= '0;
      r_pend  <= 1'b0;
    end else begin
      if (w_take) begin
        r_cause <= cause_t'(w_arb_cause);
        r_pc    <= i_pc_ex;
      end
      if (w_take && cause_t'(w_arb_cause) == C_EXT) r_pend <= 1'b0;
      else if (i_hw_int && w_ee)                    r_pend <= 1'b1;
    end
  end

  // Next state and per-state outputs.
  always_comb begin
    w_state_nxt = r_state;
    o_ivor_idx  = 4'd0;
    o_flush     = 1'b0;
    o_spr_we    = 1'b0;
    o_spr_sel   = 2'd0;
    o_spr_wdata = '0;
    o_npc_we    = 1'b0;
    o_npc       = '0;
    o_stall     = (r_state != S_IDLE);
    o_busy      = (r_state != S_IDLE);
    if (r_state != S_IDLE) o_ivor_idx = cause_ivor(r_cause);
    case (r_state)
      S_IDLE: begin
        // Gate with reset so flush is quiet while reset is held.
        o_flush = w_take & i_rst_n;
        if (w_take)
          w_state_nxt = (cause_t'(w_arb_cause) == C_RFI) ? S_RFI_M : S_SAVE0;
      end
      S_SAVE0: begin
        o_spr_we    = 1'b1;
        o_spr_sel   = SEL_SRR0;
        o_spr_wdata = SPR_W'(w_save_pc);
        w_state_nxt = S_SAVE1;
      end
      S_SAVE1: begin
        o_spr_we    = 1'b1;
        o_spr_sel   = SEL_SRR1;
        o_spr_wdata = i_msr;
        w_state_nxt = S_MSRW;
      end
      S_MSRW: begin
        o_spr_we    = 1'b1;
        o_spr_sel   = SEL_MSR;
        o_spr_wdata = i_msr & ~w_ee_mask;
        w_state_nxt = S_JUMP;
      end
      S_JUMP: begin
        o_npc_we    = 1'b1;
        o_npc       = PC_W'(w_vec);
        w_state_nxt = S_IDLE;
      end
      S_RFI_M: begin
        o_spr_we    = 1'b1;
        o_spr_sel   = SEL_MSR;
        o_spr_wdata = i_srr1;
        w_state_nxt = S_RFI_J;
      end
      S_RFI_J: begin
        o_npc_we    = 1'b1;
        o_npc       = PC_W'(w_ret);
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_int_seq.sv
// Directed bench for int_seq: table of full entry/rfi sequences plus
// hand-written reset, pending-interrupt and EE corner cases.
module tb_int_seq;

  logic        clk, rst_n;
  logic        trap_req, sc_req, rfi_req, hw_int;
  logic [31:0] pc_ex, msr, srr0, srr1, ivpr, ivor;
  logic [3:0]  ivor_idx;
  logic        stall, flush, spr_we, npc_we, busy;
  logic [1:0]  spr_sel;
  logic [31:0] spr_wdata, npc;

  int n_tests = 0;
  int n_fail  = 0;

  int_seq #(.SPR_W(32), .PC_W(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_trap_req(trap_req), .i_sc_req(sc_req), .i_rfi_req(rfi_req),
    .i_hw_int(hw_int), .i_pc_ex(pc_ex), .i_msr(msr), .i_srr0(srr0),
    .i_srr1(srr1), .i_ivpr(ivpr), .i_ivor(ivor),
    .o_ivor_idx(ivor_idx), .o_stall(stall), .o_flush(flush),
    .o_spr_we(spr_we), .o_spr_sel(spr_sel), .o_spr_wdata(spr_wdata),
    .o_npc_we(npc_we), .o_npc(npc), .o_busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  req;      // {trap, sc, rfi}
    logic [31:0] pc, msr, srr0, srr1, ivpr, ivor;
    logic [3:0]  e_idx;
    logic [31:0] e_srr0, e_srr1, e_msr, e_npc;
    int          e_lat;    // cycles from taking edge to npc_we
    int          e_nwr;    // number of SPR writes
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic idle_inputs();
    trap_req = 0; sc_req = 0; rfi_req = 0; hw_int = 0;
  endtask

  // Present a request in an IDLE cycle, then watch 8 cycles of the sequence.
  task automatic run_vec(input int i, input vec_t v);
    logic [31:0] g_srr0, g_srr1, g_msr, g_npc;
    logic [3:0]  g_idx;
    int g_lat, g_nwr, g_both;
    g_srr0 = 0; g_srr1 = 0; g_msr = 0; g_npc = 0; g_idx = 0;
    g_lat = -1; g_nwr = 0; g_both = 0;
    @(negedge clk);
    pc_ex = v.pc; msr = v.msr; srr0 = v.srr0; srr1 = v.srr1;
    ivpr = v.ivpr; ivor = v.ivor;
    {trap_req, sc_req, rfi_req} = v.req;
    #1;
    chk($sformatf("v%0d flush", i), {31'd0, flush}, 32'd1);
    chk($sformatf("v%0d idle_busy", i), {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    idle_inputs();
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) g_idx = ivor_idx;
      if (spr_we) begin
        g_nwr++;
        case (spr_sel)
          2'd0: g_srr0 = spr_wdata;
          2'd1: g_srr1 = spr_wdata;
          default: g_msr = spr_wdata;
        endcase
      end
      if (npc_we) begin g_npc = npc; g_lat = c; end
      if (spr_we && npc_we) g_both++;
    end
    if (v.req[2:1] != 2'b00) begin
      chk($sformatf("v%0d ivor_idx", i), {28'd0, g_idx}, {28'd0, v.e_idx});
      chk($sformatf("v%0d srr0", i), g_srr0, v.e_srr0);
      chk($sformatf("v%0d srr1", i), g_srr1, v.e_srr1);
    end
    chk($sformatf("v%0d msr", i), g_msr, v.e_msr);
    chk($sformatf("v%0d npc", i), g_npc, v.e_npc);
    chk($sformatf("v%0d latency", i), g_lat, v.e_lat);
    chk($sformatf("v%0d nwr", i), g_nwr, v.e_nwr);
    chk($sformatf("v%0d we_overlap", i), g_both, 0);
    chk($sformatf("v%0d end_busy", i), {31'd0, busy}, 32'd0);
  endtask

  task automatic chk_zero_outs(input string name);
    chk({name, " ctl"}, {27'd0, stall, flush, spr_we, npc_we, busy}, 32'd0);
    chk({name, " idx_sel"}, {26'd0, ivor_idx, spr_sel}, 32'd0);
    chk({name, " wdata"}, spr_wdata, 32'd0);
    chk({name, " npc"}, npc, 32'd0);
  endtask

  initial begin
    int nmsr;
    //            req     pc            msr           srr0          srr1          ivpr          ivor          idx  srr0          srr1          msr           npc           lat nwr
    vecs[0] = '{3'b010, 32'h00001000, 32'h00008000, 32'h0,        32'h0,        32'hFFFF0000, 32'h00000120, 4'd8, 32'h00001004, 32'h00008000, 32'h00000000, 32'hFFFF0120, 4, 3};
    vecs[1] = '{3'b110, 32'h00000200, 32'h00008000, 32'h0,        32'h0,        32'h12340000, 32'h00000060, 4'd6, 32'h00000200, 32'h00008000, 32'h00000000, 32'h12340060, 4, 3};
    vecs[2] = '{3'b100, 32'h0000ABC0, 32'hFFFFFFFF, 32'h0,        32'h0,        32'h00010000, 32'h0000FFFF, 4'd6, 32'h0000ABC0, 32'hFFFFFFFF, 32'hFFFF7FFF, 32'h0001FFF0, 4, 3};
    vecs[3] = '{3'b010, 32'hFFFFFFFC, 32'h00000000, 32'h0,        32'h0,        32'h00000000, 32'h00001234, 4'd8, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00001230, 4, 3};
    vecs[4] = '{3'b001, 32'h00000500, 32'h00000000, 32'h00002003, 32'h00008000, 32'h0,        32'h0,        4'd0, 32'h0,        32'h0,        32'h00008000, 32'h00002000, 2, 1};
    vecs[5] = '{3'b001, 32'h00000000, 32'h00008000, 32'hFFFFFFFF, 32'h12345678, 32'h0,        32'h0,        4'd0, 32'h0,        32'h0,        32'h12345678, 32'hFFFFFFFC, 2, 1};
    vecs[6] = '{3'b011, 32'h00000040, 32'h00008000, 32'h0,        32'h0,        32'hABCD0000, 32'h00000700, 4'd8, 32'h00000044, 32'h00008000, 32'h00000000, 32'hABCD0700, 4, 3};

    idle_inputs();
    pc_ex = 0; msr = 0; srr0 = 0; srr1 = 0; ivpr = 0; ivor = 0;
    rst_n = 0;
    repeat (2) @(negedge clk);
    chk_zero_outs("reset");
    rst_n = 1;
    @(negedge clk);
    chk_zero_outs("post_reset_idle");

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // hw_int pulse with EE=1 during a busy sc sequence: ext taken after return.
    @(negedge clk);
    msr = 32'h00008000; pc_ex = 32'h00000100; ivpr = 32'h00000000; ivor = 32'h00000040;
    sc_req = 1;
    @(posedge clk); #1; sc_req = 0; pc_ex = 32'h00003000;
    @(negedge clk);                 // SAVE0
    hw_int = 1;
    @(negedge clk); hw_int = 0;     // SAVE1
    @(negedge clk);                 // MSRW
    @(negedge clk);                 // JUMP
    chk("ee1 jump", {31'd0, npc_we}, 32'd1);
    @(negedge clk);                 // IDLE, ext taken here
    chk("ee1 idle_busy", {31'd0, busy}, 32'd0);
    chk("ee1 idle_flush", {31'd0, flush}, 32'd1);
    @(negedge clk);                 // SAVE0 for ext
    chk("ee1 ext_idx", {28'd0, ivor_idx}, 32'd4);
    chk("ee1 ext_srr0", spr_wdata, 32'h00003000);
    repeat (3) @(negedge clk);      // SAVE1, MSRW, JUMP
    chk("ee1 ext_npc", npc, 32'h00000040);
    repeat (3) @(negedge clk);
    chk("ee1 no_retake", {30'd0, busy, flush}, 32'd0);

    // Same pulse with EE=0: nothing pends, no entry once EE is restored.
    @(negedge clk);
    msr = 32'h00000000; sc_req = 1;
    @(posedge clk); #1; sc_req = 0;
    @(negedge clk); hw_int = 1;
    @(negedge clk); hw_int = 0;
    repeat (3) @(negedge clk);      // MSRW, JUMP, IDLE
    msr = 32'h00008000;
    repeat (4) @(negedge clk);
    chk("ee0 no_entry", {30'd0, busy, flush}, 32'd0);

    // Reset while in SAVE1: outputs drop at once, no MSR write afterwards.
    @(negedge clk);
    msr = 32'h00008000; trap_req = 1;
    @(posedge clk); #1; trap_req = 0;
    @(negedge clk);                 // SAVE0
    @(negedge clk);                 // SAVE1
    chk("rst_mid save1_we", {30'd0, spr_we, spr_sel[0]}, 32'd3);
    rst_n = 0; #1;
    chk_zero_outs("rst_mid");
    @(negedge clk);
    rst_n = 1;
    nmsr = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (spr_we || busy) nmsr++;
    end
    chk("rst_mid no_resume", nmsr, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
